// File: rtl/dtw_result_filter_if.sv
// Result-FIFO read port and AXI-Stream output bundled for the DTW result filter.
// The filter is the master; the FIFO/DMA environment is the slave.
interface dtw_result_filter_if #(
  parameter int AXIS_WIDTH = 32
);
  logic                  src_fifo_rden;
  logic                  src_fifo_empty;
  logic [31:0]           src_fifo_data;
  logic [AXIS_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output src_fifo_rden,
    input  src_fifo_empty,
    input  src_fifo_data,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  src_fifo_rden,
    output src_fifo_empty,
    output src_fifo_data,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/dtw_result_filter.sv
// Drains 3-word DTW result records (qid, position, minval), applies a match threshold,
// keeps accept/reject statistics and re-emits records as 3-beat AXI-Stream packets.
module dtw_result_filter #(
  parameter int WIDTH      = 16,
  parameter int AXIS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  dtw_result_filter_if.master bus,
  input  logic [WIDTH-1:0]    threshold_i,
  input  logic                drop_rejects_i,
  input  logic                clear_stats_i,
  output logic                busy_o,
  output logic [31:0]         n_records_o,
  output logic [31:0]         n_accept_o,
  output logic                fmt_err_o,
  output logic [2:0]          dbg_state_o
);

  localparam logic [2:0] RD_QID = 3'd0;
  localparam logic [2:0] RD_POS = 3'd1;
  localparam logic [2:0] RD_VAL = 3'd2;
  localparam logic [2:0] DECIDE = 3'd3;
  localparam logic [2:0] EMIT0  = 3'd4;
  localparam logic [2:0] EMIT1  = 3'd5;
  localparam logic [2:0] EMIT2  = 3'd6;

  logic [2:0]            state_q,  state_d;
  logic [31:0]           qid_q,    qid_d;
  logic [31:0]           pos_q,    pos_d;
  logic [WIDTH-1:0]      minval_q, minval_d;
  logic                  accept_q, accept_d;
  logic [AXIS_WIDTH-1:0] tdata_q,  tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q,  tlast_d;
  logic [31:0]           nrec_q,   nrec_d;
  logic [31:0]           nacc_q,   nacc_d;
  logic                  fmt_q,    fmt_d;

  logic                  readState;
  logic                  acceptNow;
  logic                  recInc;
  logic                  accInc;
  logic [31:0]           hiBits;
  logic [AXIS_WIDTH-1:0] lastBeat;

  assign readState = (state_q == RD_QID) || (state_q == RD_POS) || (state_q == RD_VAL);
  assign hiBits    = bus.src_fifo_data >> WIDTH;

  always_comb begin
    lastBeat                 = '0;
    lastBeat[WIDTH-1:0]      = minval_q;
    lastBeat[AXIS_WIDTH-1]   = accept_q;
  end

  always_comb begin
    state_d   = state_q;
    qid_d     = qid_q;
    pos_d     = pos_q;
    minval_d  = minval_q;
    accept_d  = accept_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    fmt_d     = fmt_q;
    acceptNow = 1'b0;
    recInc    = 1'b0;
    accInc    = 1'b0;

    case (state_q)
      RD_QID: if (!bus.src_fifo_empty) begin
        qid_d   = bus.src_fifo_data;
        state_d = RD_POS;
      end
      RD_POS: if (!bus.src_fifo_empty) begin
        pos_d   = bus.src_fifo_data;
        state_d = RD_VAL;
      end
      RD_VAL: if (!bus.src_fifo_empty) begin
        minval_d = bus.src_fifo_data[WIDTH-1:0];
        if (hiBits != 32'd0) fmt_d = 1'b1;
        state_d  = DECIDE;
      end
      DECIDE: begin
        acceptNow = (minval_q <= threshold_i);
        accept_d  = acceptNow;
        recInc    = 1'b1;
        accInc    = acceptNow;
        if (drop_rejects_i && !acceptNow) begin
          state_d = RD_QID;
        end else begin
          tvalid_d = 1'b1;
          tdata_d  = AXIS_WIDTH'(qid_q);
          tlast_d  = 1'b0;
          state_d  = EMIT0;
        end
      end
      // Each handshake loads the following beat directly, so the stream has no bubbles.
      EMIT0: if (bus.m_axis_tready) begin
        tdata_d = AXIS_WIDTH'(pos_q);
        state_d = EMIT1;
      end
      EMIT1: if (bus.m_axis_tready) begin
        tdata_d = lastBeat;
        tlast_d = 1'b1;
        state_d = EMIT2;
      end
      EMIT2: if (bus.m_axis_tready) begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        state_d  = RD_QID;
      end
      default: state_d = RD_QID;
    endcase

    nrec_d = nrec_q;
    nacc_d = nacc_q;
    if (recInc && (nrec_q != 32'hFFFF_FFFF)) nrec_d = nrec_q + 32'd1;
    if (accInc && (nacc_q != 32'hFFFF_FFFF)) nacc_d = nacc_q + 32'd1;
    // A clear wins over any increment or format error arriving in the same cycle.
    if (clear_stats_i) begin
      nrec_d = '0;
      nacc_d = '0;
      fmt_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RD_QID;
      qid_q    <= '0;
      pos_q    <= '0;
      minval_q <= '0;
      accept_q <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      nrec_q   <= '0;
      nacc_q   <= '0;
      fmt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      qid_q    <= qid_d;
      pos_q    <= pos_d;
      minval_q <= minval_d;
      accept_q <= accept_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      nrec_q   <= nrec_d;
      nacc_q   <= nacc_d;
      fmt_q    <= fmt_d;
    end
  end

  assign bus.src_fifo_rden = readState && !bus.src_fifo_empty;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign busy_o            = (state_q != RD_QID);
  assign n_records_o       = nrec_q;
  assign n_accept_o        = nacc_q;
  assign fmt_err_o         = fmt_q;
  assign dbg_state_o       = state_q;

endmodule
